aes_core_arbiter: RTL
=====================

// Module: aes_core_arbiter
// PURPOSE
//   Shares one AES encrypt core and its key-expansion core between NREQ host-side requesters.
//   Each job is one 128-bit block plus a key; the core returns results in issue order.
//   The block does three things:
//   - picks requesters round-robin and issues one job at a time, honouring core_full;
//   - records the issuing requester in an in-flight tag FIFO;
//   - routes each returning c_ready result back to the requester that issued it.
//   It sits between the host register interfaces and the encrypt/key-expansion cores.
// PARAMETERS
//   NREQ   2   number of requesters, legal 2..4
//   DEPTH  4   in-flight tag FIFO entries, power of 2, max jobs outstanding in the core
//   TAGW   2   tag width, must be >= clog2(NREQ)
// PORTS
//   CLK         in   1         clock
//   RSTB        in   1         reset, asynchronous, active-low
//   req_valid   in   NREQ      requester i has a job pending; held until req_ready[i]
//   req_op      in   NREQ      per-requester op: 1 encrypt, 0 decrypt
//   req_ksz     in   2*NREQ    key size code: 0=128, 1=192, 2=256, 3=illegal
//   req_text    in   128*NREQ  per-requester plaintext block
//   req_key     in   256*NREQ  per-requester key; unused high bits are 0
//   req_ready   out  NREQ      one-cycle accept pulse, at most one bit set (one-hot)
//   core_full   in   1         core cannot take a job this cycle
//   c_ready     in   1         ciphertext valid this cycle (one-cycle pulse)
//   ciphertext  in   128       result data
//   t_ready     out  1         text-issue strobe to the core
//   k_ready     out  1         key-issue strobe to the core, asserted with t_ready
//   plain_text  out  128       issued block
//   cipher_key  out  256       issued key
//   nk_val      out  4         4/6/8
//   nr          out  4         10/12/14
//   op          out  1         issued op
//   rsp_valid   out  NREQ      one-hot result strobe
//   rsp_data    out  128       result data; valid while any rsp_valid bit is set
//   err_ksz     out  1         pulse: an illegal-ksz job was dropped
//   err_orphan  out  1         pulse: c_ready arrived with the tag FIFO empty
//   inflight    out  TAGW+1    current FIFO count
// BEHAVIOUR
//   Reset: every output is 0, FSM=IDLE, round-robin pointer=0, FIFO empty. Reset mid-job drops all in-flight tags.
//   FSM states and transitions:
//   - IDLE: arbitrate if any req_valid, ~core_full and FIFO not full.
//     - Winner = first valid requester at or after the pointer, wrapping.
//     - req_ready[winner]=1 combinationally in this cycle; the pointer moves to winner+1 mod NREQ.
//     - Legal ksz: go to ISSUE and register the outputs.
//     - ksz=3: pulse err_ksz next cycle, stay in IDLE, no issue, no FIFO push.
//   - ISSUE (1 cycle): t_ready=k_ready=1; plain_text, cipher_key, op, nk_val and nr are driven from the winner.
//     - Decode: ksz 0/1/2 gives nk_val 4/6/8 and nr 10/12/14.
//     - Push the winner tag into the FIFO. Go to GAP.
//   - GAP (1 cycle): all data outputs return to 0, strobes are 0. Go to IDLE.
//     - Minimum issue spacing is therefore 3 cycles.
//   Issue gating: core_full is sampled only in IDLE; core_full rising during ISSUE/GAP does not abort the job.
//   Result path: c_ready with the FIFO non-empty pops the head tag t.
//     - Next cycle: rsp_valid[t]=1 for one cycle and rsp_data=ciphertext captured at the c_ready edge.
//     - rsp_data holds its last value otherwise.
//   c_ready with the FIFO empty: err_orphan pulses next cycle, no rsp_valid, FIFO unchanged.
//   Simultaneous FIFO push (ISSUE) and pop (c_ready): both take effect and the count is unchanged.
//   Tag FIFO full boundary:
//   - A full FIFO (count==DEPTH) blocks arbitration; a pop in that same cycle unblocks it from the next cycle.
//   - Overflow is impossible by construction.
//   Pointer wrap-around: starting from NREQ-1 the search wraps to 0.
//   Fairness bound: with every requester always valid, grants rotate 0,1,..,NREQ-1,0.
// STRUCTURE
//   Package aes_pkg holds:
//   - KSZ_128/192/256/ILL codes;
//   - the NK_* and NR_* constants;
//   - the ksz->{nk,nr} decode function, shared with the key-expansion side.
//   Sub-module aes_tag_fifo (WIDTH=TAGW, DEPTH):
//   - sync FIFO with push, pop, head, count, full, empty;
//   - async active-low reset;
//   - simultaneous push/pop allowed.
//   The top level holds the FSM, the round-robin search, the output registers and the response register.
// TESTING
//   1. Req0 only: ksz=0, text=0x00112233..ff, key=0x000102..0f, op=1.
//      -> req_ready[0] in the accept cycle.
//      -> Next cycle t_ready=k_ready=1, nk_val=4, nr=10, plain_text=text.
//      -> c_ready with ct=0x69c4..c55a -> rsp_valid[0] one cycle later, rsp_data=ct.
//   2. NREQ=3, all three valid continuously, core_full=0.
//      -> Grants in order 0,1,2,0, each issue 3 cycles apart.
//      -> The FIFO fills to 4 and arbitration stalls until c_ready.
//      -> Responses are routed to 0,1,2,0 in that order.
//   3. core_full=1 while req1 is valid.
//      -> No req_ready and no t_ready.
//      -> core_full drops -> the grant happens in that same cycle.
//   4. req0 with ksz=3, req1 with ksz=2, both valid.
//      -> req_ready[0] and err_ksz pulse, no issue.
//      -> Then req1 issues with nk_val=8, nr=14.
//   5. c_ready with an empty FIFO -> err_orphan=1 for one cycle, rsp_valid stays 0.
//      ISSUE coinciding with c_ready at count=2 -> count stays 2.
//   6. Assert RSTB low during ISSUE with 2 jobs in flight.
//      -> All outputs 0 and inflight=0; after release the first grant goes to req0.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes_pkg
// Brief  : Shared AES key-size codes, Nk/Nr constants, ksz decode and the
//          arbiter FSM state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam logic [1:0] KSZ_128 = 2'd0;
    localparam logic [1:0] KSZ_192 = 2'd1;
    localparam logic [1:0] KSZ_256 = 2'd2;
    localparam logic [1:0] KSZ_ILL = 2'd3;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam int         ST_W    = 2;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    typedef struct packed {
        logic [3:0] nk;
        logic [3:0] nr;
    } ks_dec_t;

    // Key-size code to key words / round count; the illegal code decodes to 0.
    function automatic ks_dec_t ksz_decode(input logic [1:0] ksz);
        ks_dec_t d;
        case (ksz)
            KSZ_128: begin d.nk = NK_128; d.nr = NR_128; end
            KSZ_192: begin d.nk = NK_192; d.nr = NR_192; end
            KSZ_256: begin d.nk = NK_256; d.nr = NR_256; end
            default: begin d.nk = 4'd0;   d.nr = 4'd0;   end
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module : aes_tag_fifo
// Brief  : Small synchronous FIFO holding the requester tag of each job that
//          is in flight in the AES core. Push and pop may coincide.
// Rev    : 1.0  initial release
// ============================================================================
module aes_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNTW-1:0]  o_count,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CNTW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNTW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    // A push into a full FIFO is only accepted when a pop frees a slot.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rp];
    assign o_count   = r_count;

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge CLK) begin
        if (w_do_push) r_mem[r_wp] <= i_din;
    end

    // Pointers and occupancy count.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module : aes_core_arbiter
// Brief  : Round-robin arbiter sharing one AES encrypt/key-expansion core
//          between NREQ requesters; routes in-order results back by tag.
// Rev    : 1.0  initial release
// ============================================================================
module aes_core_arbiter
    import aes_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DEPTH = 4,
    parameter int TAGW  = 2
) (
    input  logic                CLK,
    input  logic                RSTB,
    input  logic [NREQ-1:0]     i_req_valid,
    input  logic [NREQ-1:0]     i_req_op,
    input  logic [2*NREQ-1:0]   i_req_ksz,
    input  logic [128*NREQ-1:0] i_req_text,
    input  logic [256*NREQ-1:0] i_req_key,
    output logic [NREQ-1:0]     o_req_ready,
    input  logic                i_core_full,
    input  logic                i_c_ready,
    input  logic [127:0]        i_ciphertext,
    output logic                o_t_ready,
    output logic                o_k_ready,
    output logic [127:0]        o_plain_text,
    output logic [255:0]        o_cipher_key,
    output logic [3:0]          o_nk_val,
    output logic [3:0]          o_nr,
    output logic                o_op,
    output logic [NREQ-1:0]     o_rsp_valid,
    output logic [127:0]        o_rsp_data,
    output logic                o_err_ksz,
    output logic                o_err_orphan,
    output logic [TAGW:0]       o_inflight
);
    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_next;
    logic [TAGW-1:0] r_ptr;
    logic [TAGW-1:0] r_tag;
    logic [TAGW-1:0] w_win;
    logic [TAGW-1:0] w_head;
    logic            w_found;
    logic            w_arb;
    logic            w_load;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            r_run;
    logic [NREQ-1:0] w_grant;
    logic [NREQ-1:0] w_rsp_oh;
    logic [127:0]    w_sel_text;
    logic [255:0]    w_sel_key;
    logic [1:0]      w_sel_ksz;
    logic            w_sel_op;
    ks_dec_t         w_dec;

    // Arbitration is held off while reset is asserted so req_ready stays 0.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) r_run <= 1'b0;
        else       r_run <= 1'b1;
    end

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!w_found && i_req_valid[j] && (j == ((int'(r_ptr) + k) % NREQ))) begin
                    w_found = 1'b1;
                    w_win   = TAGW'(j);
                end
            end
        end
    end

    // Winner payload mux plus one-hot decodes of winner and popped tag.
    always_comb begin
        w_sel_text = '0;
        w_sel_key  = '0;
        w_sel_ksz  = '0;
        w_sel_op   = 1'b0;
        w_grant    = '0;
        w_rsp_oh   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_win == TAGW'(j)) begin
                w_sel_text = i_req_text[j*128 +: 128];
                w_sel_key  = i_req_key[j*256 +: 256];
                w_sel_ksz  = i_req_ksz[j*2 +: 2];
                w_sel_op   = i_req_op[j];
                w_grant[j] = w_arb;
            end
            w_rsp_oh[j] = (w_head == TAGW'(j));
        end
    end

    assign w_dec = ksz_decode(w_sel_ksz);

    // FSM state register.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // FSM next-state: IDLE -> ISSUE -> GAP -> IDLE for every legal grant.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_load) w_next = S_ISSUE;
            S_ISSUE: w_next = S_GAP;
            S_GAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs: grant only in IDLE with core and tag FIFO both able to take a job.
    always_comb begin
        w_arb  = (r_state == S_IDLE) & r_run & w_found & ~i_core_full & ~w_full;
        w_load = w_arb & (w_sel_ksz != KSZ_ILL);
        w_drop = w_arb & (w_sel_ksz == KSZ_ILL);
        w_push = (r_state == S_ISSUE);
    end

    assign o_req_ready = w_grant;
    assign w_pop       = i_c_ready & ~w_empty;

    // Pointer advance past the winner, and winner tag held for the FIFO push.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_ptr <= '0;
            r_tag <= '0;
        end else begin
            if (w_arb)  r_ptr <= (w_win == TAGW'(NREQ-1)) ? '0 : w_win + 1'b1;
            if (w_load) r_tag <= w_win;
        end
    end

    // Issue registers: loaded at grant, driven during ISSUE, cleared for GAP.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            o_t_ready    <= 1'b0;
            o_k_ready    <= 1'b0;
            o_plain_text <= '0;
            o_cipher_key <= '0;
            o_nk_val     <= '0;
            o_nr         <= '0;
            o_op         <= 1'b0;
        end else if (w_load) begin
            o_t_ready    <= 1'b1;
            o_k_ready    <= 1'b1;
            o_plain_text <= w_sel_text;
            o_cipher_key <= w_sel_key;
            o_nk_val     <= w_dec.nk;
            o_nr         <= w_dec.nr;
            o_op         <= w_sel_op;
        end else if (r_state == S_ISSUE) begin
            o_t_ready    <= 1'b0;
            o_k_ready    <= 1'b0;
            o_plain_text <= '0;
            o_cipher_key <= '0;
            o_nk_val     <= '0;
            o_nr         <= '0;
            o_op         <= 1'b0;
        end
    end

    // Response routing and error pulses; rsp_data holds between results.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            o_rsp_valid  <= '0;
            o_rsp_data   <= '0;
            o_err_ksz    <= 1'b0;
            o_err_orphan <= 1'b0;
        end else begin
            o_rsp_valid  <= w_pop ? w_rsp_oh : '0;
            if (w_pop) o_rsp_data <= i_ciphertext;
            o_err_ksz    <= w_drop;
            o_err_orphan <= i_c_ready & w_empty;
        end
    end

    aes_tag_fifo #(
        .WIDTH (TAGW),
        .DEPTH (DEPTH),
        .CNTW  (TAGW + 1)
    ) u_tag_fifo (
        .CLK     (CLK),
        .RSTB    (RSTB),
        .i_push  (w_push),
        .i_din   (r_tag),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (o_inflight),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
`default_nettype wire
